// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter for the single-ported data memory: port 0 is the CPU, port 1 the loader/debug port.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give port 0 absolute priority (default is round-robin).
module dmem_access_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1   // legal range 1..15
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_e_read,
    output logic              mem_e_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              e_read_q;
    logic              e_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              req_any;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign req_any = req0 | req1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks; port 1 only gets MEM when port 0 is quiet.
    assign win = ~req0;
`else
    logic ptr_q;

    assign win = (req0 && req1) ? ptr_q : req1;
`endif

    assign win_we    = win ? we1    : we0;
    assign win_addr  = win ? addr1  : addr0;
    assign win_wdata = win ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge areset) begin
        // NOTE: the datapath registers are reset too, because mem_addr, mem_wdata and rdata are visible outputs with defined reset values.
        if (!areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            e_read_q  <= 1'b0;
            e_write_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    done_q <= 2'b00;
                    if (req_any) begin
                        addr_q    <= win_addr;
                        wdata_q   <= win_wdata;
                        e_read_q  <= ~win_we;
                        e_write_q <= win_we;
                        gnt_q     <= win ? 2'b10 : 2'b01;
                        cnt_q     <= CNT_LOAD;
                        state_q   <= ST_ACCESS;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        ptr_q     <= ~win;
`endif
                    end
                end

                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        // Last enable cycle: MEM output is valid now, so a read captures here.
                        if (e_read_q) begin
                            if (gnt_q[1]) begin
                                rdata1_q <= mem_rdata;
                            end else begin
                                rdata0_q <= mem_rdata;
                            end
                        end
                        e_read_q  <= 1'b0;
                        e_write_q <= 1'b0;
                        done_q    <= gnt_q;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    done_q  <= 2'b00;
                    gnt_q   <= 2'b00;
                    state_q <= ST_IDLE;
                end

                default: begin
                    e_read_q  <= 1'b0;
                    e_write_q <= 1'b0;
                    gnt_q     <= 2'b00;
                    done_q    <= 2'b00;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_e_read  = e_read_q;
    assign mem_e_write = e_write_q;

    // Ownership and enables are one-hot-or-zero by construction; these catch future edits that break that.
    a_gnt_excl: assert property (@(posedge clk) disable iff (!areset) !(gnt_q[0] && gnt_q[1]));
    a_en_excl:  assert property (@(posedge clk) disable iff (!areset) !(e_read_q && e_write_q));

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: directed vector table, corner-case sequences,
// and random traffic checked against a transaction-schedule model of the arbiter.
module tb_dmem_access_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int N_RAND = 1000;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    // Instance A: MEM_LATENCY = 1
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_e_read, mem_e_write;
    logic [31:0] mem_a [16] = '{default: 32'h0};

    always @(posedge clk) if (mem_e_write) mem_a[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_a[mem_addr];

    // Instance B: MEM_LATENCY = 3, read-only backing store
    logic        b_req1, b_we1;
    logic [3:0]  b_addr1;
    logic [31:0] b_wdata1;
    logic        b_gnt0, b_gnt1, b_done0, b_done1;
    logic [31:0] b_rdata0, b_rdata1;
    logic [3:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic        b_mem_e_read, b_mem_e_write;
    logic [31:0] mem_b [16] = '{5: 32'hCAFEF00D, default: 32'h0};

    assign b_mem_rdata = mem_b[b_mem_addr];

    dmem_access_arbiter #(.ADDR_W(4), .DATA_W(32), .MEM_LATENCY(LAT_A)) dut (
        .clk(clk), .areset(areset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_e_read(mem_e_read), .mem_e_write(mem_e_write), .mem_rdata(mem_rdata)
    );

    dmem_access_arbiter #(.ADDR_W(4), .DATA_W(32), .MEM_LATENCY(LAT_B)) dut_b (
        .clk(clk), .areset(areset),
        .req0(1'b0), .req1(b_req1), .we0(1'b0), .we1(b_we1),
        .addr0(4'h0), .addr1(b_addr1), .wdata0(32'h0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_e_read(b_mem_e_read), .mem_e_write(b_mem_e_write), .mem_rdata(b_mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // One isolated transaction starting from IDLE, checked cycle by cycle.
    task automatic run_txn(input vec_t v, input string tag);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        tick();
        check({tag, ".gnt"},       (v.port == 1) ? gnt1 : gnt0, 32'd1);
        check({tag, ".gnt_other"}, (v.port == 1) ? gnt0 : gnt1, 32'd0);
        check({tag, ".e_read"},    mem_e_read,  {31'd0, ~v.we});
        check({tag, ".e_write"},   mem_e_write, {31'd0, v.we});
        check({tag, ".mem_addr"},  mem_addr,    v.addr);
        check({tag, ".mem_wdata"}, mem_wdata,   v.wdata);
        for (int k = 1; k < LAT_A; k++) tick();
        tick();
        check({tag, ".done"}, (v.port == 1) ? done1 : done0, 32'd1);
        check({tag, ".en_off"}, mem_e_read | mem_e_write, 32'd0);
        if (!v.we) check({tag, ".rdata"}, (v.port == 1) ? rdata1 : rdata0, v.exp_rdata);
        set_port(v.port, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check({tag, ".done_end"}, (v.port == 1) ? done1 : done0, 32'd0);
        check({tag, ".gnt_end"},  gnt0 | gnt1, 32'd0);
    endtask

    // Random requesters
    bit          rq [2];
    bit          rw [2];
    logic [3:0]  ra [2];
    logic [31:0] rd [2];
    logic [31:0] ref_mem [16];

    task automatic new_req(input int p);
        rq[p] = 1'b1;
        rw[p] = 1'($urandom_range(0, 1));
        ra[p] = 4'($urandom_range(0, 15));
        rd[p] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_w;
        int e_cnt, done_at;

        vecs[0] = '{1, 1'b1, 4'h8, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 4'h8, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 4'h3, 32'h12345678, 32'h0};
        vecs[3] = '{1, 1'b0, 4'h3, 32'h0,        32'h12345678};
        vecs[4] = '{1, 1'b0, 4'hF, 32'h0,        32'h0};
        vecs[5] = '{0, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0};
        vecs[6] = '{0, 1'b0, 4'hF, 32'h0,        32'hA5A5A5A5};

        areset = 1'b0;
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0);
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = 4'h0; b_wdata1 = 32'h0;

        // Reset values
        tick(); tick();
        check("rst.gnt0", gnt0, 0);           check("rst.gnt1", gnt1, 0);
        check("rst.done0", done0, 0);         check("rst.done1", done1, 0);
        check("rst.e_read", mem_e_read, 0);   check("rst.e_write", mem_e_write, 0);
        check("rst.mem_addr", mem_addr, 0);   check("rst.mem_wdata", mem_wdata, 0);
        check("rst.rdata0", rdata0, 0);       check("rst.rdata1", rdata1, 0);
        areset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset during ACCESS drops the transaction
        set_port(0, 1'b1, 1'b0, 4'h8, 32'h0);
        tick();
        check("rstmid.gnt0_before", gnt0, 1);
        areset = 1'b0;
        #1;
        check("rstmid.gnt0", gnt0, 0);        check("rstmid.gnt1", gnt1, 0);
        check("rstmid.e_read", mem_e_read, 0); check("rstmid.e_write", mem_e_write, 0);
        check("rstmid.rdata0", rdata0, 0);
        tick();
        check("rstmid.no_done0", done0, 0);
        areset = 1'b1;
        tick();
        check("rstmid.regrant", gnt0, 1);
        check("rstmid.regrant_rd", mem_e_read, 1);
        tick();
        check("rstmid.done0", done0, 1);
        check("rstmid.rdata0_after", rdata0, 32'hDEADBEEF);
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check("rstmid.idle", gnt0 | gnt1, 0);

        // Contention from reset with both ports held back-to-back
        areset = 1'b0;
        tick();
        areset = 1'b1;
        set_port(0, 1'b1, 1'b1, 4'h1, 32'h11111111);
        set_port(1, 1'b1, 1'b1, 4'h2, 32'h22222222);
        tick();
        check("cont1.gnt0", gnt0, 1); check("cont1.gnt1", gnt1, 0);
        check("cont1.addr", mem_addr, 4'h1);
        tick();
        check("cont1.done0", done0, 1);
        tick();
        check("cont.idle", gnt0 | gnt1, 0);
        tick();
        exp_w = FIXED ? 0 : 1;
        check("cont2.gnt0", gnt0, (exp_w == 0) ? 1 : 0);
        check("cont2.gnt1", gnt1, (exp_w == 1) ? 1 : 0);
        check("cont2.addr", mem_addr, (exp_w == 1) ? 4'h2 : 4'h1);
        tick();
        check("cont2.done", (exp_w == 1) ? done1 : done0, 1);
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();

        // Latency 3 read on port 1 of instance B
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 4'h5;
        e_cnt = 0; done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (b_mem_e_read) e_cnt++;
            if (b_done1 && done_at < 0) begin
                done_at = i;
                check("lat3.rdata1", b_rdata1, 32'hCAFEF00D);
                check("lat3.gnt1_in_done", b_gnt1, 1);
                b_req1 = 1'b0;
            end
        end
        check("lat3.e_read_cycles", e_cnt, 3);
        check("lat3.done_edge", done_at, 4);

        // Random traffic against the schedule model
        areset = 1'b0;
        tick();
        areset = 1'b1;
        for (int k = 0; k < 16; k++) ref_mem[k] = mem_a[k];
        rq[0] = 1'b0; rq[1] = 1'b0;
        begin
            int  next_free = 0, s = -100, tp = 0, ptr = 0, w;
            bit  have = 1'b0, twe = 1'b0, in_gnt, in_en, dn;
            logic [3:0]  exp_maddr = 4'h0, taddr = 4'h0;
            logic [31:0] exp_mwdata = 32'h0, twdata = 32'h0, trd = 32'h0;
            logic [31:0] exp_rd [2];
            exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
            for (int e = 0; e < N_RAND; e++) begin
                set_port(0, rq[0], rw[0], ra[0], rd[0]);
                set_port(1, rq[1], rw[1], ra[1], rd[1]);
                @(posedge clk);
                if (e == next_free) begin
                    if (rq[0] || rq[1]) begin
                        w = (rq[0] && rq[1]) ? (FIXED ? 0 : ptr) : (rq[1] ? 1 : 0);
                        ptr = 1 - w;
                        have = 1'b1; s = e; tp = w;
                        twe = rw[w]; taddr = ra[w]; twdata = rd[w];
                        if (twe) ref_mem[taddr] = twdata;
                        else     trd = ref_mem[taddr];
                        exp_maddr = taddr; exp_mwdata = twdata;
                        next_free = e + LAT_A + 2;
                    end else begin
                        next_free = e + 1;
                    end
                end
                #1;
                in_gnt = have && (e >= s) && (e <= s + LAT_A);
                in_en  = have && (e >= s) && (e <  s + LAT_A);
                dn     = have && (e == s + LAT_A);
                if (dn && !twe) exp_rd[tp] = trd;
                check("rnd.gnt0",  gnt0,  {31'd0, in_gnt && tp == 0});
                check("rnd.gnt1",  gnt1,  {31'd0, in_gnt && tp == 1});
                check("rnd.done0", done0, {31'd0, dn && tp == 0});
                check("rnd.done1", done1, {31'd0, dn && tp == 1});
                check("rnd.e_read",  mem_e_read,  {31'd0, in_en && !twe});
                check("rnd.e_write", mem_e_write, {31'd0, in_en && twe});
                check("rnd.rdata0", rdata0, exp_rd[0]);
                check("rnd.rdata1", rdata1, exp_rd[1]);
                check("rnd.mem_addr",  mem_addr,  exp_maddr);
                check("rnd.mem_wdata", mem_wdata, exp_mwdata);
                check("rnd.gnt_excl", gnt0 & gnt1, 0);
                check("rnd.en_excl",  mem_e_read & mem_e_write, 0);
                for (int p = 0; p < 2; p++) begin
                    if (rq[p]) begin
                        if (dn && tp == p) begin
                            if ($urandom_range(0, 2) == 0) new_req(p);
                            else rq[p] = 1'b0;
                        end
                    end else if ($urandom_range(0, 1) == 1) begin
                        new_req(p);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
